// File: rtl/state_replay_feeder_pkg.sv
// Shared constants and width helpers for the State0/State1 feeder and its replay FIFO.
package state_replay_feeder_pkg;

    // Legal values of the BURST parameter.
    localparam string BurstYes = "yes";
    localparam string BurstNo  = "no";

    // Width of one packed sample vector.
    function automatic int unsigned vecWidth(input int unsigned np, input int unsigned wv);
        return np * wv;
    endfunction

    // Width of an occupancy counter that can hold the value depth itself.
    function automatic int unsigned countWidth(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/replay_fifo.sv
// In-order circular FIFO with a first-word-fall-through output register.
// The caller must only push while oCount < DEPTH; oCount includes the entry held
// in the output register.
module replay_fifo
    import state_replay_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 40,
    parameter string       BURST = "yes"
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic                         iPushValid,
    input  logic [W-1:0]                 iPushData,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [W-1:0]                 oData,
    output logic [countWidth(DEPTH)-1:0] oCount
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = countWidth(DEPTH);
    localparam bit          Burst = (BURST == BurstYes);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rdPtrQ, rdPtrD;
    logic [PW-1:0] wrPtrQ, wrPtrD;
    logic [CW-1:0] countQ, countD;
    logic [CW-1:0] ramCount;
    logic          outValidQ, outValidD;
    logic [W-1:0]  outDataQ, outDataD;
    logic          ramEmpty;
    logic          outFree;
    logic          pop;
    logic          load;
    logic          bypass;
    logic          ramWrite;

    // Decide output-register reload, buffer read/write and the next occupancy.
    always_comb begin
        ramCount = countQ - {{(CW-1){1'b0}}, outValidQ};
        ramEmpty = (ramCount == '0);
        pop      = outValidQ & iReady;
        // Without burst, a register drained this edge cannot be reloaded this edge.
        outFree  = !outValidQ | (Burst & iReady);
        load     = outFree & (!ramEmpty | iPushValid);
        // Empty buffer: the pushed word goes straight to the output register.
        bypass   = load & ramEmpty & iPushValid;
        ramWrite = iPushValid & !bypass;

        rdPtrD    = (load && !ramEmpty) ? rdPtrQ + PW'(1) : rdPtrQ;
        wrPtrD    = ramWrite ? wrPtrQ + PW'(1) : wrPtrQ;
        outValidD = outValidQ;
        outDataD  = outDataQ;
        if (load) begin
            outValidD = 1'b1;
            outDataD  = ramEmpty ? iPushData : mem[rdPtrQ];
        end else if (pop) begin
            outValidD = 1'b0;
        end

        countD = countQ;
        if (iPushValid && !pop) begin
            countD = countQ + CW'(1);
        end else if (!iPushValid && pop) begin
            countD = countQ - CW'(1);
        end
    end

    // Pointer, count and output register state.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            rdPtrQ    <= '0;
            wrPtrQ    <= '0;
            countQ    <= '0;
            outValidQ <= 1'b0;
            outDataQ  <= '0;
        end else begin
            rdPtrQ    <= rdPtrD;
            wrPtrQ    <= wrPtrD;
            countQ    <= countD;
            outValidQ <= outValidD;
            outDataQ  <= outDataD;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge iClk) begin
        if (ramWrite) begin
            mem[wrPtrQ] <= iPushData;
        end
    end

    assign oValid = outValidQ;
    assign oData  = outDataQ;
    assign oCount = countQ;

endmodule

// File: rtl/state_replay_feeder.sv
// Forwards host samples as State0 and, in training mode, replays them in order as State1.
module state_replay_feeder
    import state_replay_feeder_pkg::*;
#(
    parameter int unsigned NP    = 8,
    parameter int unsigned WV    = 5,
    parameter int unsigned DEPTH = 4,
    parameter string       BURST = "yes"
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iMode,
    input  logic                         iValid_AM_Sample,
    output logic                         oReady_AM_Sample,
    input  logic [vecWidth(NP, WV)-1:0]  iData_AM_Sample,
    output logic                         oValid_BM_State0,
    input  logic                         iReady_BM_State0,
    output logic [vecWidth(NP, WV)-1:0]  oData_BM_State0,
    output logic                         oValid_BM_State1,
    input  logic                         iReady_BM_State1,
    output logic [vecWidth(NP, WV)-1:0]  oData_BM_State1,
    output logic [countWidth(DEPTH)-1:0] oCount
);

    localparam int unsigned VW    = vecWidth(NP, WV);
    localparam int unsigned CW    = countWidth(DEPTH);
    localparam bit          Burst = (BURST == BurstYes);

    logic          s0ValidQ, s0ValidD;
    logic [VW-1:0] s0DataQ, s0DataD;
    logic          s0Free;
    logic          accept;
    logic          push;
    logic [CW-1:0] fifoCount;

    // Acceptance handshake; the full check uses the count before any same-cycle pop.
    always_comb begin
        s0Free           = !s0ValidQ | (Burst & iReady_BM_State0);
        oReady_AM_Sample = s0Free & (!iMode | (fifoCount < CW'(DEPTH)));
        accept           = iValid_AM_Sample & oReady_AM_Sample;
        push             = accept & iMode;
    end

    // State0 register next state: load on accept, clear on drain.
    always_comb begin
        s0ValidD = s0ValidQ;
        s0DataD  = s0DataQ;
        if (accept) begin
            s0ValidD = 1'b1;
            s0DataD  = iData_AM_Sample;
        end else if (s0ValidQ && iReady_BM_State0) begin
            s0ValidD = 1'b0;
        end
    end

    // State0 output register.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s0ValidQ <= 1'b0;
            s0DataQ  <= '0;
        end else begin
            s0ValidQ <= s0ValidD;
            s0DataQ  <= s0DataD;
        end
    end

    replay_fifo #(
        .DEPTH (DEPTH),
        .W     (VW),
        .BURST (BURST)
    ) uReplayFifo (
        .iClk       (iCLK),
        .iRst       (iRST),
        .iPushValid (push),
        .iPushData  (iData_AM_Sample),
        .oValid     (oValid_BM_State1),
        .iReady     (iReady_BM_State1),
        .oData      (oData_BM_State1),
        .oCount     (fifoCount)
    );

    assign oValid_BM_State0 = s0ValidQ;
    assign oData_BM_State0  = s0DataQ;
    assign oCount           = fifoCount;

endmodule
